// File: rtl/cpu_bus_master.sv
// CPU bus-cycle generator: turns single valid/ready read/write requests into
// timed CS_/OE_/WR_ cycles with registered strobes and a one-cycle response.
module cpu_bus_master #(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic       clk_cpu,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_wr,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       CS_,
   output logic       OE_,
   output logic       WR_,
   output logic [7:0] Addr,
   inout  wire  [7:0] data_bus
);

   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC);
   localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       wr_q, wr_nxt;
   logic [7:0] wdata_q, wdata_nxt;
   logic [7:0] addr_nxt, rdata_nxt;
   logic       drive_q, drive_nxt;
   logic       cs_nxt, oe_nxt, we_nxt, ready_nxt, rsp_valid_nxt;
   logic       expire;

   assign expire   = (cnt == 4'd1);
   assign data_bus = drive_q ? wdata_q : 'z;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wr_nxt    = wr_q;
      wdata_nxt = wdata_q;
      addr_nxt  = Addr;
      rdata_nxt = rsp_rdata;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               state_nxt = SETUP;
               cnt_nxt   = SETUP_LD;
               wr_nxt    = req_wr;
               wdata_nxt = req_wdata;
               addr_nxt  = req_addr;
            end
         end
         SETUP: begin
            if (expire) begin
               state_nxt = STROBE;
               cnt_nxt   = STROBE_LD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         STROBE: begin
            if (expire) begin
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LD;
               // slave read data is registered, so it is only valid by the last strobe cycle
               if (!wr_q) rdata_nxt = data_bus;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         HOLD: begin
            if (expire) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // outputs are decoded from the next state so they come straight off flops
      cs_nxt        = (state_nxt == IDLE);
      oe_nxt        = !((state_nxt == STROBE) && !wr_nxt);
      we_nxt        = !((state_nxt == STROBE) && wr_nxt);
      drive_nxt     = wr_nxt && (state_nxt != IDLE);
      ready_nxt     = (state_nxt == IDLE);
      rsp_valid_nxt = (state == HOLD) && (state_nxt == IDLE);
   end

   always_ff @(posedge clk_cpu or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         drive_q   <= 1'b0;
         Addr      <= '0;
         rsp_rdata <= '0;
         rsp_valid <= 1'b0;
         req_ready <= 1'b1;
         CS_       <= 1'b1;
         OE_       <= 1'b1;
         WR_       <= 1'b1;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         wr_q      <= wr_nxt;
         wdata_q   <= wdata_nxt;
         drive_q   <= drive_nxt;
         Addr      <= addr_nxt;
         rsp_rdata <= rdata_nxt;
         rsp_valid <= rsp_valid_nxt;
         req_ready <= ready_nxt;
         CS_       <= cs_nxt;
         OE_       <= oe_nxt;
         WR_       <= we_nxt;
      end
   end

endmodule

// File: tb/tb_cpu_bus_master.sv
// Randomized bench for cpu_bus_master: two parameter sets, each with a register
// slave model, checked cycle by cycle against a phase/timing reference model.
module tb_cpu_bus_master;

   logic clk_cpu = 1'b0;
   always #5 clk_cpu = ~clk_cpu;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : inst
      localparam int unsigned S = (g == 0) ? 1 : 2;
      localparam int unsigned T = (g == 0) ? 2 : 4;
      localparam int unsigned H = (g == 0) ? 1 : 2;
      localparam int unsigned L = S + T + H;

      logic       rst = 1'b0;
      logic       req_valid = 1'b0;
      logic       req_wr = 1'b0;
      logic [7:0] req_addr = '0;
      logic [7:0] req_wdata = '0;
      logic       req_ready, rsp_valid, CS_, OE_, WR_;
      logic [7:0] rsp_rdata, Addr;
      wire  [7:0] data_bus;
      logic       done = 1'b0;

      logic [7:0] exp_mem [256];
      logic [7:0] sl_mem [256];
      logic       load = 1'b1;
      logic       sl_vld;
      logic [7:0] sl_q;
      logic [7:0] last_rd = '0;
      logic [7:0] last_addr = '0;

      pullup (data_bus);

      cpu_bus_master #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
         .clk_cpu   (clk_cpu),
         .rst       (rst),
         .req_valid (req_valid),
         .req_ready (req_ready),
         .req_wr    (req_wr),
         .req_addr  (req_addr),
         .req_wdata (req_wdata),
         .rsp_valid (rsp_valid),
         .rsp_rdata (rsp_rdata),
         .CS_       (CS_),
         .OE_       (OE_),
         .WR_       (WR_),
         .Addr      (Addr),
         .data_bus  (data_bus)
      );

      // register slave: synchronous write, read data registered one cycle after OE_ falls
      always @(posedge clk_cpu) begin
         if (load) begin
            for (int i = 0; i < 256; i++) sl_mem[i] <= exp_mem[i];
         end else if (!CS_ && !WR_) begin
            sl_mem[Addr] <= data_bus;
         end
         if (!load && !CS_ && !OE_) begin
            sl_vld <= 1'b1;
            sl_q   <= sl_mem[Addr];
         end else begin
            sl_vld <= 1'b0;
            sl_q   <= '0;
         end
      end
      assign data_bus = (sl_vld && !CS_ && !OE_) ? sl_q : 8'bz;

      // Called at a negedge with the DUT idle; returns at the negedge of the rsp_valid cycle.
      task automatic txn(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic hold);
         logic [7:0] rd_exp;
         logic [7:0] bexp;
         logic       busy, strobe;
         rd_exp = exp_mem[a];
         check_eq("ready_pre", 8'(req_ready), 8'h01);
         req_valid = 1'b1;
         req_wr    = wr;
         req_addr  = a;
         req_wdata = d;
         for (int k = 1; k <= int'(L) + 1; k++) begin
            @(negedge clk_cpu);
            if (!hold) req_valid = 1'b0;
            busy   = (k <= int'(L));
            strobe = (k > int'(S)) && (k <= int'(S + T));
            check_eq("cs", 8'(CS_), 8'(!busy));
            check_eq("wr_strobe", 8'(WR_), 8'(!(wr && strobe)));
            check_eq("oe_strobe", 8'(OE_), 8'(!(!wr && strobe)));
            check_eq("addr", Addr, a);
            check_eq("ready", 8'(req_ready), 8'(!busy));
            check_eq("rsp_valid", 8'(rsp_valid), 8'(k == int'(L) + 1));
            if (wr && busy) bexp = d;
            else if (!wr && k >= int'(S) + 2 && k <= int'(S + T)) bexp = rd_exp;
            else bexp = 8'hFF;
            check_eq("bus", data_bus, bexp);
         end
         if (wr) exp_mem[a] = d;
         else last_rd = rd_exp;
         check_eq("rdata", rsp_rdata, last_rd);
         req_valid = 1'b0;
         last_addr = a;
      endtask

      task automatic idle(input int unsigned n);
         for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk_cpu);
            check_eq("idle_cs", 8'(CS_), 8'h01);
            check_eq("idle_rsp", 8'(rsp_valid), 8'h00);
            check_eq("idle_ready", 8'(req_ready), 8'h01);
            check_eq("idle_bus", data_bus, 8'hFF);
            check_eq("idle_addr", Addr, last_addr);
            check_eq("idle_rdata", rsp_rdata, last_rd);
         end
      endtask

      task automatic check_reset_vals();
         check_eq("rst_cs", 8'(CS_), 8'h01);
         check_eq("rst_oe", 8'(OE_), 8'h01);
         check_eq("rst_wr", 8'(WR_), 8'h01);
         check_eq("rst_addr", Addr, 8'h00);
         check_eq("rst_bus", data_bus, 8'hFF);
         check_eq("rst_rsp", 8'(rsp_valid), 8'h00);
         check_eq("rst_rdata", rsp_rdata, 8'h00);
         check_eq("rst_ready", 8'(req_ready), 8'h01);
      endtask

      task automatic abort_write(input logic [7:0] a, input logic [7:0] d);
         req_valid = 1'b1;
         req_wr    = 1'b1;
         req_addr  = a;
         req_wdata = d;
         @(negedge clk_cpu);
         req_valid = 1'b0;
         @(negedge clk_cpu);
         check_eq("abort_cs_pre", 8'(CS_), 8'h00);
         check_eq("abort_bus_pre", data_bus, d);
         rst = 1'b0;
         #1;
         check_reset_vals();
         last_rd   = '0;
         last_addr = '0;
         repeat (2) begin
            @(negedge clk_cpu);
            check_eq("abort_rsp", 8'(rsp_valid), 8'h00);
            check_eq("abort_cs", 8'(CS_), 8'h01);
         end
         rst = 1'b1;
         idle(3);
      endtask

      initial begin
         logic       wr, hold;
         logic [7:0] a, d;
         for (int i = 0; i < 256; i++) exp_mem[i] = 8'($urandom);
         repeat (2) @(negedge clk_cpu);
         load = 1'b0;
         check_reset_vals();
         rst = 1'b1;
         idle(1);

         txn(1'b1, 8'h01, 8'h5A, 1'b0);
         idle(2);
         txn(1'b0, 8'h01, 8'h00, 1'b0);
         idle(1);
         txn(1'b1, 8'h02, 8'hC3, 1'b0);
         idle(1);
         txn(1'b0, 8'h02, 8'h00, 1'b0);
         idle(1);
         txn(1'b1, 8'h01, 8'h11, 1'b0);
         txn(1'b0, 8'h01, 8'h00, 1'b0);
         idle(1);
         txn(1'b1, 8'h30, 8'h77, 1'b1);
         txn(1'b0, 8'h30, 8'h00, 1'b1);
         idle(1);
         abort_write(8'h44, 8'h99);
         txn(1'b0, 8'h44, 8'h00, 1'b0);
         idle(1);

         for (int n = 0; n < 60; n++) begin
            wr   = 1'($urandom_range(0, 1));
            hold = 1'($urandom_range(0, 1));
            a    = 8'($urandom_range(0, 15));
            d    = 8'($urandom_range(0, 254));
            txn(wr, a, d, hold);
            idle($urandom_range(0, 2));
         end
         done = 1'b1;
      end
   end

   initial begin
      wait (inst[0].done && inst[1].done);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2ms;
      n_bad++;
      $display("FAIL watchdog: got no completion, expected both sequences done");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cpu_bus_master.md
# cpu_bus_master

Bus-cycle generator that sits directly upstream of the CPU-bus register slave (decode / write_reg / read_reg). It accepts single read or write requests over a valid/ready handshake and converts each into a timed CPU bus cycle on CS_, OE_, WR_, Addr and the bidirectional data_bus. Read data sampled from the slave is returned on a one-cycle response strobe. All bus timing is in clk_cpu cycles, so the slave's synchronous write and registered read paths see stable strobes.

## Interface

- SETUP_CYC, 1: cycles CS_/Addr (and write data) are asserted before the strobe; legal 1..15
- STROBE_CYC, 2: cycles OE_ or WR_ is held low; legal 2..15
- HOLD_CYC, 1: cycles CS_/Addr (and write data) are held after the strobe; legal 1..15

- clk_cpu  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  high in IDLE only; transfer on req_valid && req_ready
- req_wr  input  1  1 = write, 0 = read
- req_addr  input  8  target register address
- req_wdata  input  8  write data, ignored for reads
- rsp_valid  output  1  one-cycle pulse, transaction complete
- rsp_rdata  output  8  read data; holds the last read value
- CS_  output  1  chip select, active low
- OE_  output  1  read strobe, active low
- WR_  output  1  write strobe, active low
- Addr  output  8  bus address
- data_bus  inout  8  driven only during write cycles, otherwise high-Z

## Operation

- FSM states: IDLE, SETUP, STROBE, HOLD. A 4-bit down-counter times each state.
- IDLE: CS_=OE_=WR_=1, data_bus=Z, req_ready=1. On handshake, latch req_wr/req_addr/req_wdata, load counter with SETUP_CYC, go to SETUP.
- SETUP: CS_=0, Addr=latched address, OE_=WR_=1. For a write, data_bus=latched data. When the counter expires, go to STROBE and load STROBE_CYC.
- STROBE: write gives WR_=0 with data still driven. Read gives OE_=0 with data_bus=Z. When the counter expires, go to HOLD and load HOLD_CYC.
- HOLD: OE_=WR_=1, CS_=0, Addr held. Write data is still driven; on a read the bus is Z. When the counter expires, go to IDLE.
- Read capture: rsp_rdata <= data_bus on the clock edge that ends the last STROBE cycle. STROBE_CYC>=2 is required because the slave's read data is registered one cycle after OE_ falls.
- rsp_valid pulses high for exactly the first IDLE cycle after HOLD, for both reads and writes.
- All bus outputs are registered, so there are no combinational glitches on the strobes.
- The master never drives data_bus while OE_=0. The bus is never driven in IDLE.
- rsp_rdata is unchanged by write transactions.
- req_valid while not in IDLE: the request is not accepted and inputs are ignored. The requester must hold its fields stable until the handshake.

## Timing

- Reset values (asynchronous, while rst=0): state=IDLE, CS_=OE_=WR_=1, Addr=8'h00, data_bus=Z, rsp_valid=0, rsp_rdata=8'h00, req_ready=1.
- Reset mid-transaction: outputs return to reset values immediately and the bus is released. The transaction is dropped and rsp_valid does not pulse.
- Handshake at edge E0. Cycle numbering starts at the cycle after E0:
  - SETUP occupies cycles 1..S.
  - STROBE occupies cycles S+1..S+T.
  - HOLD occupies cycles S+T+1..S+T+H.
  - The IDLE cycle with rsp_valid=1 and req_ready=1 is cycle S+T+H+1.
- Back-to-back: a new handshake may occur in the rsp_valid cycle. CS_ is therefore high for at least one cycle between transactions.
- Addr changes only on entry to SETUP. It holds its last value in IDLE.

## Test plan

- Write, defaults. Request write 0x5A to 0x01 at cycle 0 -> CS_=0 and data_bus=0x5A in cycles 1-4; WR_=0 in cycles 2-3; Addr=0x01; rsp_valid in cycle 5; slave reg1 reads back 0x5A.
- Read, defaults. Slave reg at 0x02 holds 0xC3; request read 0x02 -> OE_=0 in cycles 2-3; data_bus never driven by the master; rsp_rdata=0xC3 with rsp_valid in cycle 5.
- Back-to-back. Write 0x11 to 0x01, then read 0x01 presented in the rsp_valid cycle -> CS_ high for exactly one cycle between the transactions; read returns 0x11.
- Busy. Hold req_valid=1 throughout a write -> req_ready=0 in cycles 1-4; exactly one transaction per IDLE handshake; no request lost or duplicated.
- Reset mid-strobe. Deassert rst in cycle 2 of a write -> CS_/WR_ go high and data_bus goes Z without waiting for a clock edge; no rsp_valid; req_ready=1 after reset release.
- Parameters SETUP_CYC=2, STROBE_CYC=4, HOLD_CYC=2, read -> OE_=0 in cycles 3-6; rsp_valid in cycle 9; correct data captured.
